alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Instruction sequencer for the 8-bit ALU datapath in the TinyTapeout ALU-FSM design. It buffers instruction bytes (`{op[1:0], imm[5:0]}`) in a small FIFO. It issues LOAD/ADD operations to the ALU datapath with a start/done handshake and drives the output-register write strobe for STORE. It sits between the `ui_in` instruction stream and the accumulator datapath, and replaces the fixed IDLE→LOAD→ADD→STORE→DONE walk with per-instruction decode.

## Interface
Parameters:
- `DEPTH`, 4 — instruction FIFO entries; power of two, 2..16.
- `TIMEOUT`, 16 — maximum WAIT cycles before watchdog abort; 2..255. Only used with `ALU_SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1 — single clock. All logic is on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `ena` in 1 — when low, no new instruction is popped. An in-flight instruction still completes.
- `instr_in` in 8 — `[7:6]` opcode: 00 NOP, 01 LOAD, 10 ADD, 11 STORE. `[5:0]` immediate.
- `instr_valid` in 1 — producer has a byte on `instr_in`.
- `instr_ready` out 1 — `count != DEPTH`. Combinational from the count register only.
- `alu_start` out 1 — one-cycle pulse requesting a datapath operation.
- `alu_op` out 2 — opcode of the current instruction. Held from DECODE until return to IDLE.
- `alu_imm` out 6 — immediate of the current instruction. Held with `alu_op`.
- `alu_done` in 1 — datapath completion. Sampled only in WAIT.
- `store_we` out 1 — one-cycle output-register write strobe for STORE.
- `busy` out 1 — `state != IDLE`.
- `store_cnt` out 8 — committed STOREs. Wraps 255→0.
- `err` out 1 — sticky watchdog flag. Cleared only by `rst`.

## Operation
- **FIFO**
  - A push occurs when `instr_valid && instr_ready`.
  - A pop occurs in IDLE when `ena` is high and the FIFO is non-empty.
  - A simultaneous push and pop leaves count unchanged. A push is never accepted at full, even if a pop happens in the same cycle.
  - Pointers wrap modulo DEPTH.
- **FSM states:** IDLE, DECODE, ISSUE, WAIT, COMMIT.
  - IDLE: if `ena` and the FIFO is non-empty, pop the head into the instruction register and go to DECODE.
  - DECODE: NOP→IDLE; LOAD/ADD→ISSUE; STORE→COMMIT.
  - ISSUE: `alu_start`=1 for exactly this cycle, then go to WAIT.
  - WAIT: `alu_done`=1 → IDLE. Otherwise stay, subject to the watchdog.
  - COMMIT: `store_we`=1 for exactly this cycle; `store_cnt`++; then go to IDLE.
- `alu_done` asserted outside WAIT is ignored.
- Taking `ena` low during DECODE, ISSUE, WAIT or COMMIT does not stall that sequence.
- **Reset values (after a rst edge):**
  - state IDLE.
  - FIFO empty, so `instr_ready`=1.
  - `alu_start`=0, `store_we`=0, `alu_op`=0, `alu_imm`=0, `busy`=0, `store_cnt`=0, `err`=0.
- **Reset mid-operation:** FIFO flushed, in-flight instruction dropped, strobes low the next cycle. No `store_we` is emitted for an aborted STORE.

## Timing
- Push accepted on edge E0 into an empty FIFO, FSM in IDLE:
  - E1: pop, state DECODE.
  - E2: state ISSUE (or COMMIT for STORE).
  - `alu_start` (or `store_we`) is high between E2 and E3.
  - E3: WAIT (or IDLE).
- A LOAD/ADD with `alu_done` high in the first WAIT cycle returns to IDLE at E4. Minimum issue interval is 4 cycles for LOAD/ADD, 3 for STORE, 2 for NOP.
- Back-to-back instructions: IDLE pops on the cycle it is entered, if non-empty.

## Configuration
- `ALU_SEQ_TIMEOUT_EN` defined:
  - An 8-bit wait counter clears on entry to WAIT and increments each WAIT cycle without `alu_done`.
  - If `alu_done` is low when the counter == TIMEOUT-1, set `err`=1 and go to IDLE. `alu_done` in that same cycle wins, with no error.
  - WAIT therefore lasts at most TIMEOUT cycles.
- Undefined: no counter. WAIT holds indefinitely and `err` is tied to 0.

## Test plan
- Reset, then push 0x41, 0x81, 0xC0, with the bench returning `alu_done` 1 cycle after each `alu_start`:
  - `alu_start` pulses with (op,imm)=(01,1) then (10,1).
  - `store_we` pulses once.
  - `store_cnt`=1 and `busy`=0 at the end.
- Push 5 bytes back-to-back with `ena`=0, DEPTH=4 → `instr_ready` drops after the 4th push and the 5th byte is not accepted. Raising `ena` then drains exactly 4 instructions in order.
- Push 0x00 (NOP) followed by 0xC5 → no `alu_start`. `store_we` is high exactly 3 cycles after the STORE is popped-eligible; `store_cnt`=1.
- With `ALU_SEQ_TIMEOUT_EN`, TIMEOUT=16, push 0x42 and never assert `alu_done` → `err`=1 after 16 WAIT cycles, FSM back in IDLE, the next instruction still processed. Repeat with `alu_done` on WAIT cycle 16 → `err`=0.
- Assert `rst` while in WAIT with 2 entries queued → next cycle: `busy`=0, `instr_ready`=1, FIFO empty, `store_cnt`=0, `err`=0, no spurious strobes.
- 256 STOREs (0xC0) → `store_cnt` wraps to 0. Pulse `alu_done` during ISSUE/IDLE → ignored, FSM still waits in WAIT.

Source files
------------

// File: rtl/alu_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl_if
//
// Purpose:
//    Bundles the instruction stream, ALU start/done handshake and STORE/status
//    signals of the ALU instruction sequencer into one interface.
//    The sequencer connects through the slave modport. The producer/datapath
//    side (or a testbench) connects through the master modport.
//
// Signal summary:
//    ena          producer -> seq   allow popping new instructions
//    instr_in     producer -> seq   {op[1:0], imm[5:0]} instruction byte
//    instr_valid  producer -> seq   instr_in holds a byte
//    instr_ready  seq -> producer   FIFO has room (count != DEPTH)
//    alu_start    seq -> datapath   one-cycle operation request
//    alu_op       seq -> datapath   opcode of the current instruction
//    alu_imm      seq -> datapath   immediate of the current instruction
//    alu_done     datapath -> seq   operation complete, sampled only in WAIT
//    store_we     seq -> datapath   one-cycle output-register write strobe
//    busy         seq -> observer   sequencer not idle
//    store_cnt    seq -> observer   committed STORE count, wraps 255 -> 0
//    err          seq -> observer   sticky watchdog flag
// ---------------------------------------------------------------------------
interface alu_seq_ctrl_if;
   logic       ena;
   logic [7:0] instr_in;
   logic       instr_valid;
   logic       instr_ready;
   logic       alu_start;
   logic [1:0] alu_op;
   logic [5:0] alu_imm;
   logic       alu_done;
   logic       store_we;
   logic       busy;
   logic [7:0] store_cnt;
   logic       err;

   // Producer/datapath view: drives the stream and the done handshake.
   modport master (
      output ena,
      output instr_in,
      output instr_valid,
      input  instr_ready,
      input  alu_start,
      input  alu_op,
      input  alu_imm,
      output alu_done,
      input  store_we,
      input  busy,
      input  store_cnt,
      input  err
   );

   // Sequencer view: consumes the stream and issues ALU operations.
   modport slave (
      input  ena,
      input  instr_in,
      input  instr_valid,
      output instr_ready,
      output alu_start,
      output alu_op,
      output alu_imm,
      input  alu_done,
      output store_we,
      output busy,
      output store_cnt,
      output err
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
//
// Purpose:
//    Instruction sequencer for the 8-bit ALU datapath. Instruction bytes
//    {op[1:0], imm[5:0]} are buffered in a DEPTH-entry FIFO, popped one at a
//    time and decoded:
//       00 NOP   -> straight back to IDLE
//       01 LOAD  -> ISSUE (alu_start pulse) then WAIT for alu_done
//       10 ADD   -> ISSUE (alu_start pulse) then WAIT for alu_done
//       11 STORE -> COMMIT (store_we pulse, store_cnt++)
//
// Parameters:
//    DEPTH    FIFO entries, power of two, 2..16
//    TIMEOUT  maximum WAIT cycles before the watchdog aborts, 2..255
//
// Ports:
//    clk   rising-edge clock
//    rst   synchronous active-high reset
//    bus   alu_seq_ctrl_if.slave, see the interface file for signal roles
//
// Build option:
//    ALU_SEQ_TIMEOUT_EN  when defined, an 8-bit watchdog limits WAIT to
//                        TIMEOUT cycles and sets the sticky err flag on
//                        expiry. When undefined, WAIT holds until alu_done
//                        and err is tied low.
// ---------------------------------------------------------------------------
module alu_seq_ctrl #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16
) (
   input logic          clk,
   input logic          rst,
   alu_seq_ctrl_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [2:0] {
      IDLE,
      DECODE,
      ISSUE,
      WAIT,
      COMMIT
   } state_t;

   state_t           state_q;

   logic [7:0]       fifoMem_q [DEPTH];
   logic [PTR_W-1:0] wrPtr_q;
   logic [PTR_W-1:0] wrPtr_d;
   logic [PTR_W-1:0] rdPtr_q;
   logic [PTR_W-1:0] rdPtr_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   logic             aluStart_q;
   logic             storeWe_q;
   logic [1:0]       aluOp_q;
   logic [5:0]       aluImm_q;
   logic [7:0]       storeCnt_q;

   logic             fifoFull;
   logic             fifoEmpty;
   logic             push;
   logic             pop;
   logic [7:0]       headInstr;

`ifdef ALU_SEQ_TIMEOUT_EN
   logic [7:0]       waitCnt_q;
   logic             err_q;
`endif

   // Full/empty come only from the count register so instr_ready never
   // depends on the pop decision; a push at full is refused even if a pop
   // frees a slot in the same cycle.
   assign fifoFull  = (count_q == CNT_W'(DEPTH));
   assign fifoEmpty = (count_q == '0);
   assign push      = bus.instr_valid && !fifoFull;
   assign pop       = (state_q == IDLE) && bus.ena && !fifoEmpty;
   assign headInstr = fifoMem_q[rdPtr_q];

   // Next-state for the FIFO pointers and occupancy. Pointers wrap naturally
   // because DEPTH is a power of two; push+pop together leaves count alone.
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (push) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (pop) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // FIFO storage. The array needs no reset: the pointers and count define
   // which entries are live, so flushing only has to clear those.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoMem_q[wrPtr_q] <= bus.instr_in;
      end
   end

   // FIFO pointer and occupancy registers; reset flushes the queue.
   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Sequencer FSM with registered strobes. The strobes default low every
   // cycle and are raised only on the transition into ISSUE or COMMIT, which
   // makes each one exactly one cycle wide and keeps them low after reset.
   // The popped instruction is captured straight into alu_op/alu_imm, which
   // therefore stay stable for the whole DECODE..WAIT/COMMIT sequence.
   // ena is only looked at in IDLE, so dropping it never stalls an
   // instruction already in flight, and alu_done is only looked at in WAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         aluStart_q <= 1'b0;
         storeWe_q  <= 1'b0;
         aluOp_q    <= 2'b00;
         aluImm_q   <= 6'd0;
         storeCnt_q <= 8'd0;
`ifdef ALU_SEQ_TIMEOUT_EN
         waitCnt_q  <= 8'd0;
         err_q      <= 1'b0;
`endif
      end else begin
         aluStart_q <= 1'b0;
         storeWe_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (pop) begin
                  aluOp_q  <= headInstr[7:6];
                  aluImm_q <= headInstr[5:0];
                  state_q  <= DECODE;
               end
            end

            DECODE: begin
               case (aluOp_q)
                  2'b00: begin
                     state_q <= IDLE;
                  end
                  2'b11: begin
                     storeWe_q <= 1'b1;
                     state_q   <= COMMIT;
                  end
                  default: begin
                     aluStart_q <= 1'b1;
                     state_q    <= ISSUE;
                  end
               endcase
            end

            ISSUE: begin
`ifdef ALU_SEQ_TIMEOUT_EN
               waitCnt_q <= 8'd0;
`endif
               state_q <= WAIT;
            end

            WAIT: begin
               if (bus.alu_done) begin
                  state_q <= IDLE;
               end
`ifdef ALU_SEQ_TIMEOUT_EN
               else if (waitCnt_q == 8'(TIMEOUT - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= IDLE;
               end else begin
                  waitCnt_q <= waitCnt_q + 8'd1;
               end
`endif
            end

            COMMIT: begin
               storeCnt_q <= storeCnt_q + 8'd1;
               state_q    <= IDLE;
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.instr_ready = !fifoFull;
   assign bus.alu_start   = aluStart_q;
   assign bus.alu_op      = aluOp_q;
   assign bus.alu_imm     = aluImm_q;
   assign bus.store_we    = storeWe_q;
   assign bus.busy        = (state_q != IDLE);
   assign bus.store_cnt   = storeCnt_q;
`ifdef ALU_SEQ_TIMEOUT_EN
   assign bus.err         = err_q;
`else
   assign bus.err         = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Directed testbench for alu_seq_ctrl (DEPTH=4, TIMEOUT=16). Inputs are
// driven 1 ns after the rising edge; a negedge monitor logs every alu_start
// (with op/imm and cycle) and every store_we. alu_done is either driven by
// hand or by an auto-responder that answers one cycle after alu_start.
// ---------------------------------------------------------------------------
module tb_alu_seq_ctrl;

   logic clk = 1'b0;
   logic rst;

   alu_seq_ctrl_if bus ();

   alu_seq_ctrl #(
      .DEPTH   (4),
      .TIMEOUT (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   int cycleCnt   = 0;
   int startCount = 0;
   int storeCount = 0;
   int lastStoreCycle = -1;
   logic [7:0] opLog[$];
   int startCycleLog[$];

   logic autoDone    = 1'b0;
   logic manualDone  = 1'b0;
   logic startPrev   = 1'b0;
   logic autoDoneVal = 1'b0;

   assign bus.alu_done = autoDone ? autoDoneVal : manualDone;

   // Cycle counter, advanced on every active edge.
   always @(posedge clk) begin
      cycleCnt <= cycleCnt + 1;
   end

   // Strobe monitor and alu_done auto-responder, sampled mid-cycle.
   // autoDoneVal goes high in the cycle after the alu_start cycle.
   always @(negedge clk) begin
      startPrev   <= bus.alu_start;
      autoDoneVal <= startPrev;
      if (bus.alu_start) begin
         startCount <= startCount + 1;
         opLog.push_back({bus.alu_op, bus.alu_imm});
         startCycleLog.push_back(cycleCnt);
      end
      if (bus.store_we) begin
         storeCount     <= storeCount + 1;
         lastStoreCycle <= cycleCnt;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one byte for one cycle; it is taken only if instr_ready was high.
   task automatic applyStimulus(input logic [7:0] instr);
      bus.instr_in    = instr;
      bus.instr_valid = 1'b1;
      tick();
      bus.instr_valid = 1'b0;
   endtask

   task automatic pushWhenReady(input logic [7:0] instr);
      int guard;
      guard = 0;
      while (!bus.instr_ready && guard < 100) begin
         tick();
         guard++;
      end
      if (!bus.instr_ready) begin
         checkOutput("readyTimeout", 32'(bus.instr_ready), 32'd1);
      end
      applyStimulus(instr);
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int c0;
      int sBase;
      int wBase;
      int oBase;
      logic [7:0] fillBytes[5];
      logic       readyBefore[5];

      rst             = 1'b1;
      bus.ena         = 1'b1;
      bus.instr_in    = 8'h00;
      bus.instr_valid = 1'b0;

      // ---------------- reset values ----------------
      doReset();
      checkOutput("rst_ready",    32'(bus.instr_ready), 32'd1);
      checkOutput("rst_busy",     32'(bus.busy),        32'd0);
      checkOutput("rst_start",    32'(bus.alu_start),   32'd0);
      checkOutput("rst_storewe",  32'(bus.store_we),    32'd0);
      checkOutput("rst_op",       32'(bus.alu_op),      32'd0);
      checkOutput("rst_imm",      32'(bus.alu_imm),     32'd0);
      checkOutput("rst_storecnt", 32'(bus.store_cnt),   32'd0);
      checkOutput("rst_err",      32'(bus.err),         32'd0);

      // ---------------- LOAD, ADD, STORE program ----------------
      autoDone = 1'b1;
      sBase = startCount;
      wBase = storeCount;
      oBase = opLog.size();
      applyStimulus(8'h41);
      c0 = cycleCnt;
      applyStimulus(8'h81);
      applyStimulus(8'hC0);
      repeat (20) tick();
      checkOutput("prog_starts",   32'(startCount - sBase), 32'd2);
      checkOutput("prog_op0",      32'(opLog[oBase]),       32'h41);
      checkOutput("prog_op1",      32'(opLog[oBase + 1]),   32'h81);
      checkOutput("prog_start0_t", 32'(startCycleLog[oBase] - c0),     32'd2);
      checkOutput("prog_start1_t", 32'(startCycleLog[oBase + 1] - c0), 32'd6);
      checkOutput("prog_stores",   32'(storeCount - wBase), 32'd1);
      checkOutput("prog_store_t",  32'(lastStoreCycle - c0), 32'd10);
      checkOutput("prog_storecnt", 32'(bus.store_cnt),      32'd1);
      checkOutput("prog_busy",     32'(bus.busy),           32'd0);

      // ---------------- NOP then STORE 0xC5 ----------------
      sBase = startCount;
      wBase = storeCount;
      applyStimulus(8'h00);
      c0 = cycleCnt;
      applyStimulus(8'hC5);
      repeat (12) tick();
      checkOutput("nop_starts",   32'(startCount - sBase), 32'd0);
      checkOutput("nop_stores",   32'(storeCount - wBase), 32'd1);
      checkOutput("nop_store_t",  32'(lastStoreCycle - c0), 32'd4);
      checkOutput("nop_storecnt", 32'(bus.store_cnt),      32'd2);

      // ---------------- fill FIFO with ena low ----------------
      bus.ena = 1'b0;
      fillBytes[0] = 8'h41;
      fillBytes[1] = 8'h82;
      fillBytes[2] = 8'h43;
      fillBytes[3] = 8'h84;
      fillBytes[4] = 8'h85;
      sBase = startCount;
      oBase = opLog.size();
      for (int i = 0; i < 5; i++) begin
         readyBefore[i] = bus.instr_ready;
         applyStimulus(fillBytes[i]);
      end
      checkOutput("full_ready4",    32'(readyBefore[3]),  32'd1);
      checkOutput("full_ready5",    32'(readyBefore[4]),  32'd0);
      checkOutput("full_ready_now", 32'(bus.instr_ready), 32'd0);
      tick();
      checkOutput("full_noissue",   32'(bus.busy),        32'd0);
      bus.ena = 1'b1;
      repeat (40) tick();
      checkOutput("drain_starts", 32'(startCount - sBase), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("drain_op%0d", i), 32'(opLog[oBase + i]), 32'(fillBytes[i]));
      end
      checkOutput("drain_ready", 32'(bus.instr_ready), 32'd1);

      // ---------------- alu_done outside WAIT is ignored ----------------
      autoDone   = 1'b0;
      manualDone = 1'b1;
      tick();
      tick();
      checkOutput("ign_idle_busy", 32'(bus.busy), 32'd0);
      manualDone = 1'b0;
      sBase = startCount;
      applyStimulus(8'h42);
      tick();
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      repeat (5) tick();
      checkOutput("ign_still_wait", 32'(bus.busy), 32'd1);
      checkOutput("ign_starts",     32'(startCount - sBase), 32'd1);
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      checkOutput("ign_released", 32'(bus.busy), 32'd0);

`ifdef ALU_SEQ_TIMEOUT_EN
      // ---------------- watchdog expiry ----------------
      doReset();
      applyStimulus(8'h42);
      repeat (18) tick();
      checkOutput("wd_pre_err",  32'(bus.err),  32'd0);
      checkOutput("wd_pre_busy", 32'(bus.busy), 32'd1);
      tick();
      checkOutput("wd_err",  32'(bus.err),  32'd1);
      checkOutput("wd_idle", 32'(bus.busy), 32'd0);
      applyStimulus(8'hC3);
      repeat (8) tick();
      checkOutput("wd_next_store", 32'(bus.store_cnt), 32'd1);
      checkOutput("wd_sticky",     32'(bus.err),       32'd1);

      // ---------------- done on the last WAIT cycle wins ----------------
      doReset();
      applyStimulus(8'h42);
      repeat (18) tick();
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      checkOutput("wd_last_idle", 32'(bus.busy), 32'd0);
      checkOutput("wd_last_err",  32'(bus.err),  32'd0);
`else
      // ---------------- WAIT holds without a watchdog ----------------
      applyStimulus(8'h42);
      repeat (40) tick();
      checkOutput("hold_busy", 32'(bus.busy), 32'd1);
      checkOutput("hold_err",  32'(bus.err),  32'd0);
      manualDone = 1'b1;
      tick();
      manualDone = 1'b0;
      checkOutput("hold_release", 32'(bus.busy), 32'd0);
`endif

      // ---------------- reset while in WAIT with 2 queued ----------------
      applyStimulus(8'h42);
      applyStimulus(8'hC1);
      applyStimulus(8'hC2);
      repeat (3) tick();
      checkOutput("mid_waiting", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      sBase = startCount;
      wBase = storeCount;
      checkOutput("mid_busy",     32'(bus.busy),        32'd0);
      checkOutput("mid_ready",    32'(bus.instr_ready), 32'd1);
      checkOutput("mid_storecnt", 32'(bus.store_cnt),   32'd0);
      checkOutput("mid_err",      32'(bus.err),         32'd0);
      checkOutput("mid_start",    32'(bus.alu_start),   32'd0);
      checkOutput("mid_storewe",  32'(bus.store_we),    32'd0);
      repeat (10) tick();
      checkOutput("mid_no_starts", 32'(startCount - sBase), 32'd0);
      checkOutput("mid_no_stores", 32'(storeCount - wBase), 32'd0);
      checkOutput("mid_idle",      32'(bus.busy),           32'd0);

      // ---------------- store_cnt wraps after 256 STOREs ----------------
      wBase = storeCount;
      for (int i = 0; i < 255; i++) begin
         pushWhenReady(8'hC0);
      end
      repeat (20) tick();
      checkOutput("wrap_255", 32'(bus.store_cnt), 32'd255);
      pushWhenReady(8'hC0);
      repeat (10) tick();
      checkOutput("wrap_0",      32'(bus.store_cnt),      32'd0);
      checkOutput("wrap_stores", 32'(storeCount - wBase), 32'd256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
